// File: rtl/fm_radio_pkg.sv
// Shared FM radio datapath constants, FSM state type and the sample quantizer.
// Quantization is sign-extension to 32 bits followed by an arithmetic left shift.
package fm_radio_pkg;

    localparam int BITS       = 10;
    localparam int DATA_WIDTH = 32;

    typedef enum logic {S_READ, S_WRITE} read_iq_state_t;

    function automatic logic signed [31:0] QUANTIZE(input logic signed [15:0] sample);
        logic signed [31:0] ext;
        ext = {{16{sample[15]}}, sample};
        return ext <<< BITS;
    endfunction

endpackage

// File: rtl/read_iq_if.sv
// Byte input FIFO read side plus I/Q output FIFO write sides of read_iq.
// master is the unpacker; slave is whatever owns the three FIFOs.
interface read_iq_if;
    import fm_radio_pkg::*;

    logic [7:0]            data_in;
    logic                  data_rd_en;
    logic                  data_empty;
    logic [DATA_WIDTH-1:0] i_out;
    logic                  i_wr_en;
    logic                  i_full;
    logic [DATA_WIDTH-1:0] q_out;
    logic                  q_wr_en;
    logic                  q_full;

    modport master (
        input  data_in, data_empty, i_full, q_full,
        output data_rd_en, i_out, i_wr_en, q_out, q_wr_en
    );

    modport slave (
        output data_in, data_empty, i_full, q_full,
        input  data_rd_en, i_out, i_wr_en, q_out, q_wr_en
    );

endinterface

// File: rtl/read_iq.sv
// Unpacks 4 little-endian bytes into a quantized I/Q pair; write is 1 cycle after the last byte pop.
// Backpressure: a full I or Q FIFO holds the pair and stops byte consumption; both FIFOs always written together.
module read_iq
    import fm_radio_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    read_iq_if.master bus
);

    read_iq_state_t state;
    read_iq_state_t state_nxt;
    logic [1:0]     byte_cnt;
    logic [23:0]    asm_reg;
    logic           pop;
    logic           push;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        if (!reset) begin
            case (state)
                S_READ: begin
                    pop = !bus.data_empty;
                    if (pop && byte_cnt == 2'd3) begin
                        state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    push = !bus.i_full && !bus.q_full;
                    if (push) begin
                        state_nxt = S_READ;
                    end
                end
                default: state_nxt = S_READ;
            endcase
        end
    end

    assign bus.data_rd_en = pop;
    assign bus.i_wr_en    = push;
    assign bus.q_wr_en    = push;

    // The final byte (Q high) is used straight from the bus, so only three bytes are buffered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_READ;
            byte_cnt  <= 2'd0;
            asm_reg   <= 24'd0;
            bus.i_out <= '0;
            bus.q_out <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: asm_reg[7:0]   <= bus.data_in;
                    2'd1: asm_reg[15:8]  <= bus.data_in;
                    2'd2: asm_reg[23:16] <= bus.data_in;
                    default: begin
                        bus.i_out <= DATA_WIDTH'(QUANTIZE($signed(asm_reg[15:0])));
                        bus.q_out <= DATA_WIDTH'(QUANTIZE($signed({bus.data_in, asm_reg[23:16]})));
                    end
                endcase
            end
        end
    end

endmodule
